e1of4_sync_rx: RTL and testbench

- Clocked receiver for the e1of4 four-phase QDI channel. It is the synchronous-domain consumer that sits at the output end of an e1of4 FIFO under test.
- It synchronises the four data rails, decodes each 1-of-4 token into 2-bit binary, and drives the enable (Rxe) handshake back to the asynchronous sender.
- Decoded tokens are buffered in a small FIFO and presented on a valid/ready interface to clocked logic.
- It keeps a running token count and a sticky code-error flag for throughput and integrity checks.

---
 rtl/e1of4_sync_rx.sv | 158 +++++++++++++++
 tb/tb_e1of4_sync_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/e1of4_sync_rx.sv
// e1of4_sync_rx: clocked receiver for a four-phase e1of4 QDI channel.
// Synchronises the rails, decodes 1-of-4 tokens, drives the Rxe handshake,
// buffers decoded values in a small FIFO and keeps token/error statistics.
module e1of4_sync_rx #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [3:0]       Rx,
   output logic             Rxe,
   output logic [1:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] token_count,
   output logic             code_err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   logic [3:0]       sync_q [SYNC_STAGES];
   logic [3:0]       rx_s;

   state_t           state_q, state_d;
   logic             rxe_q, rxe_d;
   logic [CNT_W-1:0] tok_cnt_q;
   logic             err_q;

   logic [1:0]       mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic [1:0]       hold_q;

   logic             rx_zero, rx_onehot, rx_multi;
   logic [1:0]       rx_val;
   logic             push, bad_code, pop;

   // Rail synchroniser chain; rx_s is the only view of Rx used for decisions.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= Rx;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Classify the synchronised rails and encode a one-hot code to binary.
   always_comb begin
      rx_zero   = (rx_s == '0);
      rx_multi  = ((rx_s & (rx_s - 4'd1)) != '0);
      rx_onehot = !rx_zero && !rx_multi;
      rx_val    = 2'd0;
      if (rx_s[3]) begin
         rx_val = 2'd3;
      end else if (rx_s[2]) begin
         rx_val = 2'd2;
      end else if (rx_s[1]) begin
         rx_val = 2'd1;
      end
   end

   // Handshake events are only honoured in IDLE while Rxe is offered.
   assign push     = (state_q == IDLE) && rxe_q && rx_onehot;
   assign bad_code = (state_q == IDLE) && rxe_q && rx_multi;
   assign pop      = out_ready && (count_q != '0);

   // Next state, next FIFO occupancy and next enable.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (rxe_q && !rx_zero) state_d = ACK;
         ACK:  if (rx_zero)           state_d = IDLE;
         default: state_d = IDLE;
      endcase

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end

      rxe_d = (state_d == IDLE) && (count_d < CW'(DEPTH));
   end

   // Handshake FSM with registered Rxe, token counter and sticky error flag.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         rxe_q     <= 1'b0;
         tok_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         rxe_q   <= rxe_d;
         if (push) begin
            tok_cnt_q <= tok_cnt_q + 1'b1;
         end
         if (bad_code) begin
            err_q <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset because occupancy gates visibility.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rx_val;
      end
   end

   // Remember the last presented value so out_data holds while empty.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         hold_q <= '0;
      end else begin
         hold_q <= out_data;
      end
   end

   assign out_valid   = (count_q != '0);
   assign out_data    = out_valid ? mem_q[rd_ptr_q] : hold_q;
   assign Rxe         = rxe_q;
   assign token_count = tok_cnt_q;
   assign code_err    = err_q;

endmodule

// File: tb/tb_e1of4_sync_rx.sv
// Self-checking bench for e1of4_sync_rx: directed handshake scenarios plus
// randomised tokens against a queue-based model of the channel.
module tb_e1of4_sync_rx;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned CNT_W = 4;

   logic             CLK = 1'b0;
   logic             RESET;
   logic [3:0]       Rx;
   logic             Rxe;
   logic [1:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] token_count;
   logic             code_err;

   always #5 CLK = ~CLK;

   e1of4_sync_rx #(
      .DEPTH      (DEPTH),
      .SYNC_STAGES(SYNC),
      .CNT_W      (CNT_W)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .Rx         (Rx),
      .Rxe        (Rxe),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .token_count(token_count),
      .code_err   (code_err)
   );

   int          errors = 0;
   int          checks = 0;
   int          q[$];
   int unsigned exp_cnt = 0;
   bit          exp_err = 1'b0;
   int          mode = 0;   // consumer: 0 stall, 1 always ready, 2 random, 3 one-shot

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Advance to the next falling edge, drive out_ready, and score any pop
   // that the coming rising edge will perform.
   task automatic tick();
      @(negedge CLK);
      case (mode)
         0: out_ready = 1'b0;
         1: out_ready = 1'b1;
         2: out_ready = 1'($urandom_range(0, 1));
         default: begin
            out_ready = 1'b1;
            mode = 0;
         end
      endcase
      if (!RESET && out_valid === 1'b1 && out_ready) begin
         chk("pop_avail", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) chk("pop_data", 32'(out_data), 32'(q.pop_front()));
      end
   endtask

   task automatic wait_rxe(input logic v, input string tag, input int lim);
      int n = 0;
      while (Rxe !== v && n < lim) begin
         tick();
         n++;
      end
      chk(tag, 32'(Rxe), 32'(v));
   endtask

   // Model side of a four-phase transfer: legal codes enqueue their rail index.
   task automatic model_drive(input logic [3:0] code);
      Rx = code;
      if ($countones(code) == 1) begin
         for (int k = 0; k < 4; k++) if (code[k]) q.push_back(k);
         exp_cnt++;
      end else begin
         exp_err = 1'b1;
      end
   endtask

   task automatic send(input logic [3:0] code);
      wait_rxe(1'b1, "send_rdy", 300);
      model_drive(code);
      wait_rxe(1'b0, "send_ack", SYNC + 3);
      chk("send_count", 32'(token_count), exp_cnt % (2 ** CNT_W));
      chk("send_err", 32'(code_err), 32'(exp_err));
      Rx = 4'b0000;
   endtask

   task automatic drain();
      int n = 0;
      mode = 1;
      while (out_valid !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_model", 32'(q.size()), 32'd0);
      mode = 0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      Rx = 4'b0000;
      mode = 0;
      tick();
      tick();
      RESET = 1'b0;
      q.delete();
      exp_cnt = 0;
      exp_err = 1'b0;
      tick();
   endtask

   initial begin
      int n;
      logic [3:0] c;

      RESET = 1'b1;
      Rx = 4'b0000;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_rxe", 32'(Rxe), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_count", 32'(token_count), 32'd0);
      chk("rst_err", 32'(code_err), 32'd0);
      RESET = 1'b0;
      tick();
      chk("rst_rxe_rise", 32'(Rxe), 32'd1);

      // Single token on rail 3
      model_drive(4'b1000);
      n = 0;
      while (Rxe !== 1'b0 && n < SYNC + 2) begin
         tick();
         n++;
      end
      chk("single_ack", 32'(Rxe), 32'd0);
      chk("single_data", 32'(out_data), 32'd3);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_count", 32'(token_count), 32'd1);
      Rx = 4'b0000;
      wait_rxe(1'b1, "single_rearm", SYNC + 2);
      drain();
      chk("single_hold", 32'(out_data), 32'd3);

      // Burst into a stalled consumer: fifth token must wait for a pop
      do_reset();
      for (int v = 0; v < 4; v++) send(4'(1 << v));
      repeat (SYNC + 4) tick();
      chk("burst_full_rxe", 32'(Rxe), 32'd0);
      chk("burst_full_valid", 32'(out_valid), 32'd1);
      model_drive(4'b0001);
      repeat (6) tick();
      chk("stall_rxe", 32'(Rxe), 32'd0);
      chk("stall_count", 32'(token_count), 32'd4);
      mode = 1;
      wait_rxe(1'b1, "stall_release", 10);
      wait_rxe(1'b0, "stall_ack", SYNC + 3);
      chk("stall_count2", 32'(token_count), 32'd5);
      Rx = 4'b0000;
      send(4'b0010);
      drain();
      chk("burst_count", 32'(token_count), 32'd6);

      // Illegal multi-rail code
      do_reset();
      wait_rxe(1'b1, "ill_rdy", 10);
      model_drive(4'b0101);
      wait_rxe(1'b0, "ill_ack", SYNC + 3);
      chk("ill_err", 32'(code_err), 32'd1);
      chk("ill_count", 32'(token_count), 32'd0);
      chk("ill_nopush", 32'(out_valid), 32'd0);
      repeat (5) tick();
      chk("ill_hold_rxe", 32'(Rxe), 32'd0);
      Rx = 4'b0000;
      wait_rxe(1'b1, "ill_rearm", SYNC + 2);
      chk("ill_sticky", 32'(code_err), 32'd1);
      send(4'b0100);
      drain();

      // Push and pop on the same edge with two entries buffered
      do_reset();
      send(4'b0001);
      send(4'b0010);
      wait_rxe(1'b1, "pp_rdy", 10);
      model_drive(4'b1000);
      tick();
      mode = 3;
      tick();
      tick();
      chk("pp_ack", 32'(Rxe), 32'd0);
      chk("pp_count", 32'(token_count), 32'd3);
      chk("pp_valid", 32'(out_valid), 32'd1);
      Rx = 4'b0000;
      drain();

      // Counter wrap at CNT_W=4
      do_reset();
      mode = 2;
      for (int i = 0; i < 17; i++) send(4'(1 << $urandom_range(0, 3)));
      chk("wrap_count", 32'(token_count), 32'd1);
      drain();

      // Random traffic with occasional illegal codes
      mode = 2;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            c = 4'($urandom_range(0, 15));
            while ($countones(c) < 2) c = 4'($urandom_range(0, 15));
         end else begin
            c = 4'(1 << $urandom_range(0, 3));
         end
         send(c);
      end
      drain();

      // Reset while in ACK with three entries buffered
      do_reset();
      send(4'b0001);
      send(4'b0010);
      wait_rxe(1'b1, "mid_rdy", 10);
      model_drive(4'b0100);
      wait_rxe(1'b0, "mid_ack", SYNC + 3);
      RESET = 1'b1;
      Rx = 4'b0000;
      tick();
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_count", 32'(token_count), 32'd0);
      chk("mid_rxe", 32'(Rxe), 32'd0);
      RESET = 1'b0;
      q.delete();
      exp_cnt = 0;
      exp_err = 1'b0;
      tick();
      chk("mid_rxe_rise", 32'(Rxe), 32'd1);
      send(4'b1000);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
